// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // requester side
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        lock;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        ack;
  logic [NUM_CH-1:0]        err;
  logic [DATA_W-1:0]        rdata;

  // memory side
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_ready;

  modport slave (
    input  req, lock, we, addr, wdata, mem_rdata, mem_ready,
    output gnt, ack, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, lock, we, addr, wdata, mem_rdata, mem_ready,
    input  gnt, ack, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: fixed-priority or round-robin selection,
// bus locking for back-to-back owner transfers, and an optional access timeout.
// The interface instance must be built with the same NUM_CH/ADDR_W/DATA_W.
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus
);

  localparam int OW_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // counter value at which one more stalled cycle means timeout
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    OWNED  = 2'd2
  } state_t;

  state_t              state_reg,     state_next;
  logic [OW_W-1:0]     owner_reg,     owner_next;
  logic [NUM_CH-1:0]   gnt_reg,       gnt_next;
  logic [NUM_CH-1:0]   ack_reg,       ack_next;
  logic [NUM_CH-1:0]   err_reg,       err_next;
  logic [DATA_W-1:0]   rdata_reg,     rdata_next;
  logic                mem_en_reg,    mem_en_next;
  logic                mem_we_reg,    mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg,  mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [OW_W-1:0]     rr_ptr_reg,    rr_ptr_next;
  logic [CNT_W-1:0]    cnt_reg,       cnt_next;

  logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
  logic [DATA_W-1:0]   ch_wdata [NUM_CH];
  logic [OW_W-1:0]     win;
  logic                load;
  logic [OW_W-1:0]     load_ch;
  logic [OW_W-1:0]     ptr_after_owner;

  // unpack the flat per-channel address and write-data buses
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
    assign ch_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
  end

  // winner search: from channel 0 in fixed mode, from rr_ptr (wrapping) in round-robin
  always_comb begin : p_winner
    int   idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (RR_MODE != 0) ? ((int'(rr_ptr_reg) + k) % NUM_CH) : k;
      if (!found && bus.req[idx]) begin
        win   = OW_W'(idx);
        found = 1'b1;
      end
    end
  end

  // round-robin pointer moves just past the channel that completed
  assign ptr_after_owner = (owner_reg == OW_W'(NUM_CH - 1)) ? '0 : owner_reg + OW_W'(1);

  // next-state and output logic; ack/err are pulses so they default to zero
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    gnt_next       = gnt_reg;
    ack_next       = '0;
    err_next       = '0;
    rdata_next     = rdata_reg;
    mem_en_next    = mem_en_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    load           = 1'b0;
    load_ch        = owner_reg;

    case (state_reg)
      IDLE: begin
        // a nonzero ack_reg marks the dead cycle right after a completion
        if ((bus.req != '0) && (ack_reg == '0)) begin
          load       = 1'b1;
          load_ch    = win;
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        if (bus.mem_ready) begin
          // memory completion beats a coincident timeout
          ack_next    = gnt_reg;
          mem_en_next = 1'b0;
          cnt_next    = '0;
          rr_ptr_next = ptr_after_owner;
          if (!mem_we_reg) begin
            rdata_next = bus.mem_rdata;
          end
          if (bus.lock[owner_reg]) begin
            state_next = OWNED;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if ((TIMEOUT > 0) && (cnt_reg == CNT_W'(TO_LAST))) begin
          // give up: flag the owner, keep rdata, drop any lock
          ack_next    = gnt_reg;
          err_next    = gnt_reg;
          mem_en_next = 1'b0;
          cnt_next    = '0;
          rr_ptr_next = ptr_after_owner;
          state_next  = IDLE;
          gnt_next    = '0;
        end else if (TIMEOUT > 0) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      OWNED: begin
        // only the locked owner is looked at; everyone else waits
        if (bus.req[owner_reg]) begin
          load       = 1'b1;
          load_ch    = owner_reg;
          state_next = ACCESS;
        end else if (!bus.lock[owner_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        mem_en_next = 1'b0;
      end
    endcase

    // start of a transaction: capture the channel's fields for the whole access
    if (load) begin
      owner_next     = load_ch;
      gnt_next       = NUM_CH'(1) << load_ch;
      mem_en_next    = 1'b1;
      mem_we_next    = bus.we[load_ch];
      mem_addr_next  = ch_addr[load_ch];
      mem_wdata_next = ch_wdata[load_ch];
      cnt_next       = '0;
    end
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      gnt_reg       <= '0;
      ack_reg       <= '0;
      err_reg       <= '0;
      rdata_reg     <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      gnt_reg       <= gnt_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      rdata_reg     <= rdata_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rr_ptr_reg    <= rr_ptr_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.ack       = ack_reg;
  assign bus.err       = err_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority instance with TIMEOUT=4 and
// a small memory model, plus a 4-channel round-robin instance.
module tb_mem_arbiter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_CH(2), .ADDR_W(12), .DATA_W(32)) ifa ();
  mem_arbiter_if #(.NUM_CH(4), .ADDR_W(12), .DATA_W(32)) ifr ();

  mem_arbiter #(.NUM_CH(2), .ADDR_W(12), .DATA_W(32), .RR_MODE(0), .TIMEOUT(4)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifa)
  );

  mem_arbiter #(.NUM_CH(4), .ADDR_W(12), .DATA_W(32), .RR_MODE(1), .TIMEOUT(16)) dut_r (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifr)
  );

  // memory model for the fixed-priority instance
  logic [31:0] mem [0:4095] = '{default: '0};
  assign ifa.mem_rdata = mem[ifa.mem_addr];
  always @(posedge clk) begin
    if (ifa.mem_en && ifa.mem_we && ifa.mem_ready) mem[ifa.mem_addr] <= ifa.mem_wdata;
  end

  // round-robin instance: memory always ready
  assign ifr.mem_ready = 1'b1;
  assign ifr.mem_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_g;
    ifa.req = '0; ifa.lock = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
    ifa.mem_ready = 1'b0;
    ifr.req = '0; ifr.lock = '0; ifr.we = '0; ifr.addr = '0; ifr.wdata = '0;

    // reset state
    repeat (2) step();
    chk("rst_gnt", ifa.gnt, 2'b00);
    chk("rst_ack", ifa.ack, 2'b00);
    chk("rst_err", ifa.err, 2'b00);
    chk("rst_mem_en", ifa.mem_en, 1'b0);
    chk("rst_mem_addr", ifa.mem_addr, 12'h000);
    chk("rst_rdata", ifa.rdata, 32'h0);
    chk("rst_rr_gnt", ifr.gnt, 4'h0);

    // requests while in reset are not served
    ifa.mem_ready = 1'b1;
    ifa.req = 2'b11;
    ifa.addr = {12'h002, 12'h001};
    step();
    chk("rst_hold_gnt", ifa.gnt, 2'b00);

    // fixed priority, both requesting
    nrst = 1'b1;
    step();
    chk("fp_gnt0", ifa.gnt, 2'b01);
    chk("fp_mem_en", ifa.mem_en, 1'b1);
    chk("fp_mem_addr0", ifa.mem_addr, 12'h001);
    chk("fp_ack_early", ifa.ack, 2'b00);
    step();
    chk("fp_ack0", ifa.ack, 2'b01);
    chk("fp_gnt_clr", ifa.gnt, 2'b00);
    chk("fp_mem_en_clr", ifa.mem_en, 1'b0);
    ifa.req = 2'b10;
    step();
    chk("fp_dead_ack", ifa.ack, 2'b00);
    chk("fp_dead_gnt", ifa.gnt, 2'b00);
    step();
    chk("fp_gnt1", ifa.gnt, 2'b10);
    chk("fp_mem_addr1", ifa.mem_addr, 12'h002);
    step();
    chk("fp_ack1", ifa.ack, 2'b10);
    ifa.req = 2'b00;
    step();
    chk("fp_ack1_pulse", ifa.ack, 2'b00);

    // write then read back through the memory model
    ifa.req = 2'b01; ifa.we = 2'b01;
    ifa.addr = {12'h000, 12'h010};
    ifa.wdata = {32'h0, 32'hDEADBEEF};
    step();
    chk("wr_gnt", ifa.gnt, 2'b01);
    chk("wr_mem_we", ifa.mem_we, 1'b1);
    chk("wr_mem_wdata", ifa.mem_wdata, 32'hDEADBEEF);
    step();
    chk("wr_ack", ifa.ack, 2'b01);
    chk("wr_rdata_kept", ifa.rdata, 32'h0);
    ifa.req = 2'b10; ifa.we = 2'b00;
    ifa.addr = {12'h010, 12'h010};
    step();
    chk("rd_dead_gnt", ifa.gnt, 2'b00);
    step();
    chk("rd_gnt", ifa.gnt, 2'b10);
    chk("rd_mem_we", ifa.mem_we, 1'b0);
    chk("rd_mem_addr", ifa.mem_addr, 12'h010);
    step();
    chk("rd_ack", ifa.ack, 2'b10);
    chk("rd_rdata", ifa.rdata, 32'hDEADBEEF);
    ifa.req = 2'b00;
    step();
    chk("rd_ack_pulse", ifa.ack, 2'b00);
    chk("rd_rdata_held", ifa.rdata, 32'hDEADBEEF);

    // lock: ch1 keeps the bus for three reads while ch0 waits
    ifa.req = 2'b10; ifa.lock = 2'b10;
    step();
    chk("lk_gnt1", ifa.gnt, 2'b10);
    ifa.req = 2'b11;
    step();
    chk("lk_ack_a", ifa.ack, 2'b10);
    chk("lk_owned_gnt", ifa.gnt, 2'b10);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("lk_access_gnt", ifa.gnt, 2'b10);
      chk("lk_access_ack", ifa.ack, 2'b00);
      step();
      chk("lk_ack_n", ifa.ack, 2'b10);
      chk("lk_hold_gnt", ifa.gnt, 2'b10);
    end
    ifa.req = 2'b01; ifa.lock = 2'b00;
    step();
    chk("lk_release_gnt", ifa.gnt, 2'b00);
    step();
    chk("lk_ch0_gnt", ifa.gnt, 2'b01);
    step();
    chk("lk_ch0_ack", ifa.ack, 2'b01);
    chk("lk_ch0_rdata", ifa.rdata, 32'hDEADBEEF);
    ifa.req = 2'b00;
    step();

    // timeout after 4 stalled access cycles
    ifa.mem_ready = 1'b0; ifa.req = 2'b01;
    ifa.addr = {12'h010, 12'h020};
    step();
    chk("to_gnt", ifa.gnt, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to_wait_ack", ifa.ack, 2'b00);
    end
    step();
    chk("to_ack", ifa.ack, 2'b01);
    chk("to_err", ifa.err, 2'b01);
    chk("to_rdata_kept", ifa.rdata, 32'hDEADBEEF);
    chk("to_gnt_clr", ifa.gnt, 2'b00);
    chk("to_mem_en", ifa.mem_en, 1'b0);
    ifa.req = 2'b00;
    step();
    chk("to_ack_pulse", ifa.ack, 2'b00);
    chk("to_err_pulse", ifa.err, 2'b00);

    // ready arriving on the timeout cycle is a normal completion
    ifa.req = 2'b01;
    step();
    chk("co_gnt", ifa.gnt, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("co_wait_ack", ifa.ack, 2'b00);
    end
    ifa.mem_ready = 1'b1;
    step();
    chk("co_ack", ifa.ack, 2'b01);
    chk("co_err", ifa.err, 2'b00);
    chk("co_rdata", ifa.rdata, 32'h0);
    ifa.req = 2'b00;
    step();

    // reset in the middle of an access
    ifa.mem_ready = 1'b0; ifa.req = 2'b01;
    step();
    chk("ar_gnt", ifa.gnt, 2'b01);
    step();
    nrst = 1'b0;
    #1;
    chk("ar_gnt_clr", ifa.gnt, 2'b00);
    chk("ar_mem_en", ifa.mem_en, 1'b0);
    chk("ar_mem_addr", ifa.mem_addr, 12'h000);
    step();
    chk("ar_no_ack", ifa.ack, 2'b00);
    nrst = 1'b1; ifa.mem_ready = 1'b1;
    step();
    chk("ar_regnt", ifa.gnt, 2'b01);
    chk("ar_regnt_addr", ifa.mem_addr, 12'h020);
    step();
    chk("ar_reack", ifa.ack, 2'b01);
    ifa.req = 2'b00;
    step();

    // round-robin order with all four channels requesting
    ifr.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % 4));
      step();
      chk("rr_gnt", ifr.gnt, exp_g);
      step();
      chk("rr_ack", ifr.ack, exp_g);
      step();
    end
    ifr.req = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global safety bound
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
